fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 124 ++++++++++++
 tb/tb_fetch_stage.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch: a PC register feeding a 2-entry in-order buffer that tracks
// outstanding imem requests and presents completed words to decode.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module fetch_stage #(
  parameter logic [`XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [`XLEN-1:0]      imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [`INSTR_LEN-1:0] imem_resp_data,
  input  logic                  redirect_valid,
  input  logic [`XLEN-1:0]      redirect_pc,
  output logic                  instr_valid,
  output logic [`INSTR_LEN-1:0] instr,
  output logic [`XLEN-1:0]      instr_pc,
  input  logic                  decode_ready
);
  localparam int                    XLEN    = `XLEN;
  localparam logic [XLEN-1:0]       PC_STEP = 4;
  localparam logic [`INSTR_LEN-1:0] NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {EMPTY = 2'd0, PENDING = 2'd1, FULL = 2'd2} slot_st_e;

  logic [XLEN-1:0]       pc_q, pc_d;
  slot_st_e              st_q   [2];
  slot_st_e              st_d   [2];
  logic [XLEN-1:0]       spc_q  [2];
  logic [XLEN-1:0]       spc_d  [2];
  logic [`INSTR_LEN-1:0] sins_q [2];
  logic [`INSTR_LEN-1:0] sins_d [2];
  logic                  head_q, head_d, tail_q, tail_d;
  logic [1:0]            drop_q, drop_d;

  logic [1:0] occ, pend;
  logic       req_ok, req_fire, resp_slot, resp_hit;
  logic       unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_comb begin
    occ  = {1'b0, st_q[0] != EMPTY}   + {1'b0, st_q[1] != EMPTY};
    pend = {1'b0, st_q[0] == PENDING} + {1'b0, st_q[1] == PENDING};
    // Squashed-but-unanswered requests still count against the memory's capacity.
    req_ok         = ({1'b0, occ} + {1'b0, drop_q}) < 3'd2;
    imem_req_valid = rst_n & ~redirect_valid & req_ok;
    imem_req_addr  = pc_q;
    req_fire       = imem_req_valid & imem_req_ready;
    instr_valid    = rst_n & (st_q[head_q] == FULL);
    instr          = instr_valid ? sins_q[head_q] : NOP;
    instr_pc       = instr_valid ? spc_q[head_q] : '0;
    // FULL entries always precede PENDING ones, so the oldest PENDING is head or head+1.
    resp_slot      = (st_q[head_q] == PENDING) ? head_q : ~head_q;
    resp_hit       = imem_resp_valid & (drop_q == 2'd0) & (st_q[resp_slot] == PENDING);
  end

  always_comb begin
    pc_d   = pc_q;
    head_d = head_q;
    tail_d = tail_q;
    drop_d = drop_q;
    for (int i = 0; i < 2; i++) begin
      st_d[i]   = st_q[i];
      spc_d[i]  = spc_q[i];
      sins_d[i] = sins_q[i];
    end
    if (redirect_valid) begin
      pc_d   = {redirect_pc[XLEN-1:2], 2'b00};
      head_d = 1'b0;
      tail_d = 1'b0;
      drop_d = drop_q + pend - {1'b0, imem_resp_valid};
      for (int i = 0; i < 2; i++) st_d[i] = EMPTY;
    end else begin
      if (imem_resp_valid && drop_q != 2'd0) begin
        drop_d = drop_q - 2'd1;
      end else if (resp_hit) begin
        st_d[resp_slot]   = FULL;
        sins_d[resp_slot] = imem_resp_data;
      end
      if (instr_valid && decode_ready) begin
        st_d[head_q] = EMPTY;
        head_d       = ~head_q;
      end
      if (req_fire) begin
        st_d[tail_q]  = PENDING;
        spc_d[tail_q] = pc_q;
        pc_d          = pc_q + PC_STEP;
        tail_d        = ~tail_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      head_q <= 1'b0;
      tail_q <= 1'b0;
      drop_q <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        st_q[i]   <= EMPTY;
        spc_q[i]  <= '0;
        sins_q[i] <= '0;
      end
    end else begin
      pc_q   <= pc_d;
      head_q <= head_d;
      tail_q <= tail_d;
      drop_q <= drop_d;
      for (int i = 0; i < 2; i++) begin
        st_q[i]   <= st_d[i];
        spc_q[i]  <= spc_d[i];
        sins_q[i] <= sins_d[i];
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: queue-based reference model plus an in-order memory
// model with configurable latency, driven by directed and random scenarios.
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n, imem_req_valid, imem_req_ready, imem_resp_valid;
  logic        redirect_valid, instr_valid, decode_ready;
  logic [31:0] imem_req_addr, imem_resp_data, redirect_pc, instr, instr_pc;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .decode_ready(decode_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {logic [31:0] pc; bit full; logic [31:0] ins;} ent_t;
  typedef struct {logic [31:0] addr; int due;} mreq_t;
  ent_t  mq[$];
  mreq_t memq[$];
  logic [31:0] m_pc = RESET_PC;
  int          m_drop = 0;
  int          mem_lat = 0;
  int          resp_pct = 100;
  bit          mem_en = 1'b1;

  logic        exp_rv, exp_iv;
  logic [31:0] exp_addr, exp_instr, exp_ipc;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Drive one cycle's inputs, let outputs settle and derive the expected outputs.
  task automatic apply(input bit rn, input bit rdv, input logic [31:0] rpc,
                       input bit rdy, input bit dr);
    rst_n = rn; redirect_valid = rdv; redirect_pc = rpc;
    imem_req_ready = rdy; decode_ready = dr;
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom;
    if (rn && mem_en && memq.size() > 0) begin
      if (memq[0].due <= cyc && $urandom_range(99) < resp_pct) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = instr_of(memq[0].addr);
      end
    end
    #2;
    exp_rv    = rn && !rdv && (mq.size() + m_drop < 2);
    exp_addr  = m_pc;
    exp_iv    = rn && mq.size() > 0 && mq[0].full;
    exp_instr = exp_iv ? mq[0].ins : NOP;
    exp_ipc   = exp_iv ? mq[0].pc : 32'h0;
  endtask

  // Advance the model and memory by the current cycle's inputs, then clock.
  task automatic commit();
    bit fire_m, fire_d;
    int p;
    fire_m = exp_rv && imem_req_ready;
    fire_d = imem_req_valid && imem_req_ready;
    if (!rst_n) begin
      mq.delete(); m_pc = RESET_PC; m_drop = 0;
    end else if (redirect_valid) begin
      p = 0;
      foreach (mq[i]) if (!mq[i].full) p++;
      m_drop = m_drop + p - (imem_resp_valid ? 1 : 0);
      mq.delete();
      m_pc = redirect_pc & ~32'h3;
    end else begin
      if (imem_resp_valid) begin
        if (m_drop > 0) m_drop--;
        else begin
          for (int i = 0; i < mq.size(); i++)
            if (!mq[i].full) begin mq[i].full = 1'b1; mq[i].ins = imem_resp_data; break; end
        end
      end
      if (exp_iv && decode_ready) void'(mq.pop_front());
      if (fire_m) begin mq.push_back('{m_pc, 1'b0, 32'h0}); m_pc = m_pc + 32'd4; end
    end
    if (!rst_n) memq.delete();
    else begin
      if (imem_resp_valid) void'(memq.pop_front());
      if (fire_d) memq.push_back('{imem_req_addr, cyc + 1 + $urandom_range(mem_lat)});
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic reset_dut();
    mem_en = 1'b1; mem_lat = 0; resp_pct = 100;
    repeat (2) begin apply(0, 0, 0, 1, 1); commit(); end
  endtask

  task automatic test_reset();
    mem_en = 1'b1; mem_lat = 0; resp_pct = 100;
    repeat (3) begin
      apply(0, 1'($urandom), $urandom, 1'($urandom), 1'($urandom));
      n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid got %b exp 0", imem_req_valid); end
      n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_instr_valid got %b exp 0", instr_valid); end
      n_tests++; if (instr !== NOP) begin n_fail++; $display("FAIL reset_instr got %h exp %h", instr, NOP); end
      n_tests++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL reset_instr_pc got %h exp 0", instr_pc); end
      commit();
    end
    apply(1, 0, 0, 1, 1);
    n_tests++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL first_req_valid got %b exp 1", imem_req_valid); end
    n_tests++; if (imem_req_addr !== RESET_PC) begin n_fail++; $display("FAIL first_req_addr got %h exp %h", imem_req_addr, RESET_PC); end
    commit();
  endtask

  task automatic test_stream();
    logic [31:0] nxt;
    reset_dut();
    nxt = RESET_PC;
    repeat (30) begin
      apply(1, 0, 0, 1, 1);
      n_tests++; if (imem_req_valid !== exp_rv) begin n_fail++; $display("FAIL stream_req_valid got %b exp %b", imem_req_valid, exp_rv); end
      if (instr_valid) begin
        n_tests++; if (instr_pc !== nxt) begin n_fail++; $display("FAIL stream_pc got %h exp %h", instr_pc, nxt); end
        n_tests++; if (instr !== instr_of(nxt)) begin n_fail++; $display("FAIL stream_instr got %h exp %h", instr, instr_of(nxt)); end
        nxt = nxt + 32'd4;
      end
      commit();
    end
    n_tests++; if (nxt < 32'h20) begin n_fail++; $display("FAIL stream_progress got %h exp >= 20", nxt); end
  endtask

  task automatic test_stall();
    int acc;
    bit seen;
    reset_dut();
    acc = 0;
    repeat (10) begin
      apply(1, 0, 0, 1, 0);
      if (imem_req_valid) acc++;
      if (instr_valid) begin
        n_tests++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL stall_hold_pc got %h exp 0", instr_pc); end
      end
      commit();
    end
    n_tests++; if (acc != 2) begin n_fail++; $display("FAIL stall_accepts got %0d exp 2", acc); end
    apply(1, 0, 0, 1, 0);
    n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_req_valid got %b exp 0", imem_req_valid); end
    n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin n_fail++; $display("FAIL stall_head got v=%b pc=%h exp v=1 pc=0", instr_valid, instr_pc); end
    commit();
    apply(1, 0, 0, 1, 1);
    commit();
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      apply(1, 0, 0, 1, 1);
      if (instr_valid) begin
        seen = 1'b1;
        n_tests++; if (instr_pc !== 32'h4) begin n_fail++; $display("FAIL stall_release_pc got %h exp 4", instr_pc); end
      end
      commit();
    end
    if (!seen) begin n_tests++; n_fail++; $display("FAIL stall_release_timeout got none exp pc 4"); end
  endtask

  task automatic test_redirect_pending();
    bit seen;
    reset_dut();
    mem_en = 1'b0;
    repeat (2) begin apply(1, 0, 0, 1, 0); commit(); end
    apply(1, 0, 0, 1, 0);
    n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rdp_full_req got %b exp 0", imem_req_valid); end
    commit();
    apply(1, 1, 32'h103, 1, 0);
    commit();
    apply(1, 0, 0, 1, 1);
    n_tests++; if (imem_req_addr !== 32'h100) begin n_fail++; $display("FAIL rdp_addr got %h exp 100", imem_req_addr); end
    n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rdp_drop_block got %b exp 0", imem_req_valid); end
    commit();
    mem_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      apply(1, 0, 0, 1, 1);
      n_tests++; if (imem_req_valid !== exp_rv) begin n_fail++; $display("FAIL rdp_req_valid got %b exp %b", imem_req_valid, exp_rv); end
      if (instr_valid) begin
        seen = 1'b1;
        n_tests++; if (instr_pc !== 32'h100) begin n_fail++; $display("FAIL rdp_first_pc got %h exp 100", instr_pc); end
        n_tests++; if (instr !== instr_of(32'h100)) begin n_fail++; $display("FAIL rdp_first_instr got %h exp %h", instr, instr_of(32'h100)); end
      end
      commit();
    end
    if (!seen) begin n_tests++; n_fail++; $display("FAIL rdp_timeout got none exp pc 100"); end
  endtask

  task automatic test_redirect_resp();
    reset_dut();
    apply(1, 0, 0, 1, 0);
    commit();
    apply(1, 1, 32'h40, 0, 0);
    commit();
    apply(1, 0, 0, 1, 1);
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rdr_stale_valid got %b exp 0", instr_valid); end
    n_tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40) begin n_fail++; $display("FAIL rdr_req got v=%b a=%h exp v=1 a=40", imem_req_valid, imem_req_addr); end
    commit();
    apply(1, 0, 0, 1, 1);
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rdr_early_valid got %b exp 0", instr_valid); end
    commit();
    apply(1, 0, 0, 1, 1);
    n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40) begin n_fail++; $display("FAIL rdr_target got v=%b pc=%h exp v=1 pc=40", instr_valid, instr_pc); end
    commit();
  endtask

  task automatic test_ready_low();
    reset_dut();
    repeat (5) begin
      apply(1, 0, 0, 0, 1);
      n_tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin n_fail++; $display("FAIL rdylow_req got v=%b a=%h exp v=1 a=%h", imem_req_valid, imem_req_addr, RESET_PC); end
      n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rdylow_instr_valid got %b exp 0", instr_valid); end
      commit();
    end
  endtask

  task automatic test_wrap();
    logic [31:0] nxt;
    int got;
    reset_dut();
    apply(1, 1, 32'hFFFF_FFFE, 1, 1);
    commit();
    apply(1, 0, 0, 1, 1);
    n_tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_top got v=%b a=%h exp v=1 a=fffffffc", imem_req_valid, imem_req_addr); end
    commit();
    apply(1, 0, 0, 1, 1);
    n_tests++; if (imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_zero got %h exp 0", imem_req_addr); end
    commit();
    nxt = 32'hFFFF_FFFC;
    got = 0;
    for (int i = 0; i < 10 && got < 2; i++) begin
      apply(1, 0, 0, 1, 1);
      if (instr_valid) begin
        n_tests++; if (instr_pc !== nxt) begin n_fail++; $display("FAIL wrap_pc got %h exp %h", instr_pc, nxt); end
        nxt = nxt + 32'd4;
        got++;
      end
      commit();
    end
    if (got < 2) begin n_tests++; n_fail++; $display("FAIL wrap_timeout got %0d instrs exp 2", got); end
  endtask

  task automatic test_random();
    reset_dut();
    mem_lat = 3; resp_pct = 70;
    repeat (1500) begin
      apply($urandom_range(99) != 0, $urandom_range(99) < 6, $urandom,
            $urandom_range(99) < 70, $urandom_range(99) < 60);
      n_tests++; if (imem_req_valid !== exp_rv) begin n_fail++; $display("FAIL rand_req_valid cyc %0d got %b exp %b", cyc, imem_req_valid, exp_rv); end
      n_tests++; if (imem_req_addr !== exp_addr) begin n_fail++; $display("FAIL rand_req_addr cyc %0d got %h exp %h", cyc, imem_req_addr, exp_addr); end
      n_tests++; if (instr_valid !== exp_iv) begin n_fail++; $display("FAIL rand_instr_valid cyc %0d got %b exp %b", cyc, instr_valid, exp_iv); end
      n_tests++; if (instr !== exp_instr) begin n_fail++; $display("FAIL rand_instr cyc %0d got %h exp %h", cyc, instr, exp_instr); end
      n_tests++; if (instr_pc !== exp_ipc) begin n_fail++; $display("FAIL rand_instr_pc cyc %0d got %h exp %h", cyc, instr_pc, exp_ipc); end
      commit();
    end
  endtask

  initial begin
    rst_n = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; decode_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_pending();
    test_redirect_resp();
    test_ready_low();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end
endmodule
